add_multiword_seq: RTL and testbench

ADD_MULTIWORD_SEQ -- requirements
Module: add_multiword_seq

---
 rtl/add_multiword_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_add_multiword_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_multiword_seq.sv
// ============================================================================
// add_multiword_seq
// ----------------------------------------------------------------------------
// Purpose:
//   Multi-word sequential adder. A single DATA_WIDTH-bit carry-lookahead slice
//   (add_nnbit_ahead_serial) is time-shared across WORDS slices of the
//   operands. The least-significant word is added first. The carry of each
//   slice is fed into the next word on the following clock edge.
//
//   Operation sequence:
//     IDLE --accept--> CALC (WORDS edges) --> DONE --i_rdy--> IDLE
//
// Ports:
//   i_clk    in   1                 rising-edge clock
//   i_rst    in   1                 asynchronous active-high reset
//   i_vld    in   1                 operand request valid
//   o_rdy    out  1                 ready to accept operands (IDLE only)
//   i_num_a  in   WORDS*DATA_WIDTH  operand A
//   i_num_b  in   WORDS*DATA_WIDTH  operand B
//   i_cry    in   1                 carry-in to word 0
//   i_clr    in   1                 synchronous abort, beats every other event
//   o_vld    out  1                 result valid (DONE only)
//   i_rdy    in   1                 result consumer ready
//   o_res    out  WORDS*DATA_WIDTH  sum modulo 2^(WORDS*DATA_WIDTH)
//   o_cry    out  1                 final carry-out
//   o_busy   out  1                 high while in CALC or DONE
//
// Parameters:
//   DATA_WIDTH  slice width in bits (default 8)
//   WORDS       number of slices per operand, legal range 2..16 (default 4)
// ============================================================================

// ----------------------------------------------------------------------------
// add_nnbit_ahead_serial
//   WIDTH-bit adder. The bits are split into lookahead groups of GROUP bits.
//   Inside a group, every carry is formed directly from the group carry-in
//   through the running generate/propagate terms. The group carry-outs then
//   ripple from one group to the next.
//
//   Ports: a, b (WIDTH) operands; cin carry-in; sum (WIDTH); cout carry-out.
// ----------------------------------------------------------------------------
module add_nnbit_ahead_serial #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic             grp_gen;
    logic             grp_prop;
    logic             grp_cin;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Within a group, grp_gen/grp_prop accumulate the prefix generate and
    // propagate from the group start up to bit i. The carry into bit i+1
    // then depends only on the group carry-in. It does not wait on the
    // carry of bit i.
    always_comb begin
        carry    = '0;
        grp_gen  = 1'b0;
        grp_prop = 1'b1;
        grp_cin  = cin;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i % GROUP) == 0) begin
                grp_cin  = carry[i];
                grp_gen  = 1'b0;
                grp_prop = 1'b1;
            end
            grp_gen    = gen[i] | (prop[i] & grp_gen);
            grp_prop   = grp_prop & prop[i];
            carry[i+1] = grp_gen | (grp_prop & grp_cin);
        end
    end

    assign sum  = prop ^ carry[WIDTH-1:0];
    assign cout = carry[WIDTH];

endmodule

// ----------------------------------------------------------------------------
// add_multiword_seq (top)
// ----------------------------------------------------------------------------
module add_multiword_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int WORDS      = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_vld,
    output logic                        o_rdy,
    input  logic [WORDS*DATA_WIDTH-1:0] i_num_a,
    input  logic [WORDS*DATA_WIDTH-1:0] i_num_b,
    input  logic                        i_cry,
    input  logic                        i_clr,
    output logic                        o_vld,
    input  logic                        i_rdy,
    output logic [WORDS*DATA_WIDTH-1:0] o_res,
    output logic                        o_cry,
    output logic                        o_busy
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic [DATA_WIDTH-1:0] a_words   [WORDS];
    logic [DATA_WIDTH-1:0] b_words   [WORDS];
    logic [DATA_WIDTH-1:0] res_words [WORDS];
    logic [DATA_WIDTH-1:0] slice_sum;
    logic                  slice_cout;

    // The single shared slice. idx selects which operand word is added this
    // cycle. The carry register links each word to the next one.
    add_nnbit_ahead_serial #(
        .WIDTH (DATA_WIDTH),
        .GROUP (4)
    ) u_slice (
        .a    (a_words[idx]),
        .b    (b_words[idx]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    genvar gw;
    generate
        for (gw = 0; gw < WORDS; gw++) begin : g_res
            assign o_res[gw*DATA_WIDTH +: DATA_WIDTH] = res_words[gw];
        end
    endgenerate

    // Control FSM with registered handshake outputs.
    // The abort branch sits ahead of the state case, so it overrides a
    // simultaneous accept or drain. The abort leaves the operand registers,
    // the result and o_cry untouched. As a result o_res and o_cry still move
    // only in CALC or on reset.
    // idx returns to 0 on the last CALC edge instead of incrementing, so it
    // never holds a value above WORDS-1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            o_cry  <= 1'b0;
            o_vld  <= 1'b0;
            o_rdy  <= 1'b1;
            o_busy <= 1'b0;
            for (int w = 0; w < WORDS; w++) begin
                a_words[w]   <= '0;
                b_words[w]   <= '0;
                res_words[w] <= '0;
            end
        end else if (i_clr) begin
            state  <= IDLE;
            idx    <= '0;
            o_vld  <= 1'b0;
            o_rdy  <= 1'b1;
            o_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_vld && o_rdy) begin
                        for (int w = 0; w < WORDS; w++) begin
                            a_words[w] <= i_num_a[w*DATA_WIDTH +: DATA_WIDTH];
                            b_words[w] <= i_num_b[w*DATA_WIDTH +: DATA_WIDTH];
                        end
                        carry  <= i_cry;
                        idx    <= '0;
                        state  <= CALC;
                        o_rdy  <= 1'b0;
                        o_busy <= 1'b1;
                    end
                end

                CALC: begin
                    res_words[idx] <= slice_sum;
                    carry          <= slice_cout;
                    if (idx == IDX_LAST) begin
                        o_cry <= slice_cout;
                        idx   <= '0;
                        state <= DONE;
                        o_vld <= 1'b1;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end

                DONE: begin
                    if (i_rdy) begin
                        state  <= IDLE;
                        o_vld  <= 1'b0;
                        o_rdy  <= 1'b1;
                        o_busy <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    idx    <= '0;
                    o_vld  <= 1'b0;
                    o_rdy  <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_multiword_seq.sv
// ============================================================================
// tb_add_multiword_seq
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for add_multiword_seq with DATA_WIDTH=8 and WORDS=4.
//   The bench drives directed vectors with hand-computed sums, then checks:
//     - abort and reset behaviour
//     - that requests made while busy are ignored
//     - a random run with random result stalls, checked against an
//       arithmetic model
//
// Ports: none (top-level bench).
// ============================================================================
module tb_add_multiword_seq;

    localparam int DW    = 8;
    localparam int WORDS = 4;
    localparam int NW    = DW * WORDS;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_vld;
    logic          o_rdy;
    logic [NW-1:0] i_num_a;
    logic [NW-1:0] i_num_b;
    logic          i_cry;
    logic          i_clr;
    logic          o_vld;
    logic          i_rdy;
    logic [NW-1:0] o_res;
    logic          o_cry;
    logic          o_busy;

    int checks = 0;
    int errors = 0;
    int overlap_count = 0;

    add_multiword_seq #(
        .DATA_WIDTH (DW),
        .WORDS      (WORDS)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_num_a (i_num_a),
        .i_num_b (i_num_b),
        .i_cry   (i_cry),
        .i_clr   (i_clr),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_res   (o_res),
        .o_cry   (o_cry),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // A valid result must never be offered while new operands are being
    // accepted.
    always @(negedge i_clk) begin
        if (!i_rst && o_vld && o_rdy) overlap_count++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One complete operation. The task presents the operands and counts the
    // edges until o_vld. It holds i_rdy low for 'stall' cycles while checking
    // that the result is stable, then drains the result.
    // With 'inject' set, a second request is driven during CALC.
    task automatic applyStimulus(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                 input logic cry, input logic [NW-1:0] exp_res,
                                 input logic exp_cry, input int stall,
                                 input bit inject, input string tag);
        int lat;
        @(negedge i_clk);
        i_vld   = 1'b1;
        i_num_a = a;
        i_num_b = b;
        i_cry   = cry;
        i_rdy   = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_vld = 1'b0;
        if (inject) begin
            i_vld   = 1'b1;
            i_num_a = ~a;
            i_num_b = 32'h5A5A_5A5A;
            i_cry   = ~cry;
        end
        lat = 0;
        for (int n = 1; n <= WORDS + 4; n++) begin
            if (n == 3) i_vld = 1'b0;
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_vld) begin
                lat = n;
                break;
            end
        end
        i_vld = 1'b0;
        checkOutput({tag, "_latency"}, 64'(lat), 64'(WORDS));
        checkOutput({tag, "_res"}, 64'(o_res), 64'(exp_res));
        checkOutput({tag, "_cry"}, 64'(o_cry), 64'(exp_cry));
        for (int s = 0; s < stall; s++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            checkOutput({tag, "_stall_vld"}, 64'(o_vld), 64'd1);
            checkOutput({tag, "_stall_res"}, 64'(o_res), 64'(exp_res));
            checkOutput({tag, "_stall_cry"}, 64'(o_cry), 64'(exp_cry));
        end
        i_rdy = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rdy = 1'b0;
        checkOutput({tag, "_drain_vld"}, 64'(o_vld), 64'd0);
        checkOutput({tag, "_drain_rdy"}, 64'(o_rdy), 64'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_res"},  64'(o_res),  64'd0);
        checkOutput({tag, "_cry"},  64'(o_cry),  64'd0);
        checkOutput({tag, "_vld"},  64'(o_vld),  64'd0);
        checkOutput({tag, "_busy"}, 64'(o_busy), 64'd0);
        checkOutput({tag, "_rdy"},  64'(o_rdy),  64'd1);
    endtask

    initial begin
        logic [NW-1:0] ra;
        logic [NW-1:0] rb;
        logic          rc;
        logic [NW:0]   full;
        int            vld_seen;

        i_rst   = 1'b1;
        i_vld   = 1'b0;
        i_num_a = '0;
        i_num_b = '0;
        i_cry   = 1'b0;
        i_clr   = 1'b0;
        i_rdy   = 1'b0;

        #12;
        checkResetOutputs("reset");
        @(negedge i_clk);
        i_rst = 1'b0;

        // Directed vectors
        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 0, 0, "carry_chain");
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1, 0, "overflow");
        applyStimulus(32'hF0F0_F0F0, 32'hF0F0_F0F0, 1'b0, 32'hE1E1_E1E0, 1'b1, 3, 0, "backpressure");

        // Abort at the second CALC edge. Only word 0 of the new sum has been
        // written, so the upper words still hold the previous result.
        @(negedge i_clk);
        i_vld   = 1'b1;
        i_num_a = 32'h1122_3344;
        i_num_b = 32'h0101_0101;
        i_cry   = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_vld = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_clr = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_clr = 1'b0;
        checkOutput("abort_vld",  64'(o_vld),  64'd0);
        checkOutput("abort_rdy",  64'(o_rdy),  64'd1);
        checkOutput("abort_busy", 64'(o_busy), 64'd0);
        checkOutput("abort_res",  64'(o_res),  64'hE1E1_E145);
        checkOutput("abort_cry",  64'(o_cry),  64'd1);
        vld_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_vld) vld_seen++;
        end
        checkOutput("abort_quiet", 64'(vld_seen), 64'd0);

        // An abort at the same edge as an accept wins
        @(negedge i_clk);
        i_vld = 1'b1;
        i_clr = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_vld = 1'b0;
        i_clr = 1'b0;
        checkOutput("clr_accept_busy", 64'(o_busy), 64'd0);
        checkOutput("clr_accept_rdy",  64'(o_rdy),  64'd1);

        // A request made while busy is ignored
        applyStimulus(32'h0102_0304, 32'h1020_3040, 1'b1, 32'h1122_3345, 1'b0, 0, 1, "ignored_req");

        // Reset pulsed mid-CALC
        @(negedge i_clk);
        i_vld   = 1'b1;
        i_num_a = 32'hDEAD_BEEF;
        i_num_b = 32'h0BAD_F00D;
        i_cry   = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_vld = 1'b0;
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        checkResetOutputs("mid_reset");
        @(negedge i_clk);
        i_rst = 1'b0;
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 0, 0, "after_reset");

        // Random run against the arithmetic model
        for (int t = 0; t < 1000; t++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {{NW{1'b0}}, rc};
            applyStimulus(ra, rb, rc, full[NW-1:0], full[NW],
                          int'($urandom_range(0, 3)), 0, "random");
        end

        checkOutput("vld_rdy_overlap", 64'(overlap_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
